// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts, FSM states, S-box tables.
// Consumed by aes_cipher_core and aes_round.
package aes_pkg;

    localparam logic [1:0] KL_INVALID = 2'b00;
    localparam logic [1:0] KL_128     = 2'b01;
    localparam logic [1:0] KL_192     = 2'b10;
    localparam logic [1:0] KL_256     = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_DONE
    } state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return NR_128;
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (covers the 2/3 and 9/b/d/e column coefficients)
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_round.sv
// One combinational AES round (forward, or inverse when AES_CIPHER_DEC_EN is defined).
// last=1 drops (Inv)MixColumns for the final round.
module aes_round (
    input  logic [127:0] state,
    input  logic [127:0] subkey,
    input  logic         inverse,
    input  logic         last,
    output logic [127:0] next_state
);
    import aes_pkg::*;

    // byte i sits at bits [127-8i -: 8]; column c is bytes 4c..4c+3, row r is byte 4c+r
    logic [7:0] s_in [16];
    logic [7:0] key  [16];
    logic [7:0] sr   [16];
    logic [7:0] mc   [16];
    logic [7:0] enc  [16];

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            s_in[i] = state[127 - 8*i -: 8];
            key[i]  = subkey[127 - 8*i -: 8];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                sr[4*c + r] = SBOX[s_in[4*((c + r) % 4) + r]];
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                mc[4*c + r] = gf_mul(sr[4*c + r], 4'h2) ^ gf_mul(sr[4*c + (r + 1) % 4], 4'h3)
                            ^ sr[4*c + (r + 2) % 4] ^ sr[4*c + (r + 3) % 4];
        for (int unsigned i = 0; i < 16; i++)
            enc[i] = (last ? sr[i] : mc[i]) ^ key[i];
    end

`ifdef AES_CIPHER_DEC_EN
    logic [7:0] isb [16];
    logic [7:0] ark [16];
    logic [7:0] dec [16];

    // straight inverse cipher: key is added before InvMixColumns
    always_comb begin
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                isb[4*c + r] = INV_SBOX[s_in[4*((c + 4 - r) % 4) + r]];
        for (int unsigned i = 0; i < 16; i++)
            ark[i] = isb[i] ^ key[i];
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                dec[4*c + r] = last ? ark[4*c + r]
                             : gf_mul(ark[4*c + r], 4'he) ^ gf_mul(ark[4*c + (r + 1) % 4], 4'hb)
                             ^ gf_mul(ark[4*c + (r + 2) % 4], 4'hd) ^ gf_mul(ark[4*c + (r + 3) % 4], 4'h9);
    end

    always_comb begin
        for (int unsigned i = 0; i < 16; i++)
            next_state[127 - 8*i -: 8] = inverse ? dec[i] : enc[i];
    end
`else
    logic unused_inverse;
    assign unused_inverse = inverse;

    always_comb begin
        for (int unsigned i = 0; i < 16; i++)
            next_state[127 - 8*i -: 8] = enc[i];
    end
`endif

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 core, one round per cycle in which the external key store supplies a valid subkey.
// Decrypt (straight inverse cipher) is built only with AES_CIPHER_DEC_EN defined.
module aes_cipher_core #(
    parameter int unsigned SKEY_AW = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [1:0]         key_len,
    input  logic [127:0]       data_in,
    output logic [127:0]       data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SKEY_AW-1:0] subkey_addr,
    input  logic [127:0]       subkey,
    input  logic               subkey_valid
);
    import aes_pkg::*;

    state_t             cur, nxt;
    logic [127:0]       blk_q, res_q, round_out;
    logic [3:0]         nr_q, rnd_q;
    logic [SKEY_AW-1:0] addr_q, addr_step;
    logic               accept, last_round, dec_req, dec_q;

    assign accept     = (cur == ST_IDLE) && in_valid && (key_len != KL_INVALID);
    assign last_round = (rnd_q == nr_q);
    assign addr_step  = dec_q ? addr_q - SKEY_AW'(1) : addr_q + SKEY_AW'(1);

`ifdef AES_CIPHER_DEC_EN
    assign dec_req = mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    dec_q <= 1'b0;
        else if (accept) dec_q <= mode;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign dec_req     = 1'b0;
    assign dec_q       = 1'b0;
`endif

    aes_round u_round (
        .state      (blk_q),
        .subkey     (subkey),
        .inverse    (dec_q),
        .last       (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= ST_IDLE;
        else          cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (cur)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) nxt = ST_INIT;
            end
            ST_INIT:  if (subkey_valid) nxt = ST_ROUND;
            ST_ROUND: if (subkey_valid && last_round) nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q  <= '0;
            res_q  <= '0;
            nr_q   <= '0;
            rnd_q  <= '0;
            addr_q <= '0;
        end else begin
            case (cur)
                ST_IDLE: if (accept) begin
                    blk_q  <= data_in;
                    nr_q   <= nr_of(key_len);
                    rnd_q  <= '0;
                    addr_q <= dec_req ? SKEY_AW'(nr_of(key_len)) : '0;
                end
                ST_INIT: if (subkey_valid) begin
                    blk_q  <= blk_q ^ subkey;
                    rnd_q  <= 4'd1;
                    addr_q <= addr_step;
                end
                // the last round lands only in the result register; the working state is left as is
                ST_ROUND: if (subkey_valid) begin
                    if (last_round) begin
                        res_q <= round_out;
                    end else begin
                        blk_q  <= round_out;
                        rnd_q  <= rnd_q + 4'd1;
                        addr_q <= addr_step;
                    end
                end
                ST_DONE: if (out_ready) begin
                    rnd_q  <= '0;
                    addr_q <= '0;
                end
            endcase
        end
    end

    assign data_out    = res_q;
    assign subkey_addr = addr_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: FIPS-197 vectors with an in-bench key schedule feeding the subkey port,
// subkey stalls, output backpressure, invalid key length and mid-block reset.
module tb_aes_cipher_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [1:0]   key_len;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid;

    always #5 clk = ~clk;

    aes_cipher_core #(.SKEY_AW(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .key_len      (key_len),
        .data_in      (data_in),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .subkey_addr  (subkey_addr),
        .subkey       (subkey),
        .subkey_valid (subkey_valid)
    );

`ifdef AES_CIPHER_DEC_EN
    localparam bit DEC_ON = 1'b1;
`else
    localparam bit DEC_ON = 1'b0;
`endif

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [1:0]   kl;
        logic         md;
        logic [127:0] din;
        int           gap;
        logic [127:0] exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic [127:0] rk [16];
    int           nr_cur;
    int           n_pass = 0;
    int           n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (v^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] y;
        y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, v);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // FIPS-197 key schedule for the sequential key 00 01 02 ...
    task automatic expand(input logic [1:0] kl);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        nk = (kl == 2'b01) ? 4 : (kl == 2'b10) ? 6 : 8;
        nr_cur = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        for (int i = nk; i < 4*(nr_cur + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
    endtask

    task automatic run(input logic [1:0] kl, input logic md, input logic [127:0] din, input int gap,
                       output logic [127:0] dout, output int edges, output int stalls, output int addr_err);
        int k;
        bit sv;
        bit eff_dec;
        eff_dec = md && DEC_ON;
        expand(kl);
        @(negedge clk);
        in_valid = 1'b1;
        key_len  = kl;
        mode     = md;
        data_in  = din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        key_len  = 2'b00;
        mode     = ~md;
        data_in  = ~din;
        edges = 0;
        stalls = 0;
        addr_err = 0;
        k = 0;
        while (!out_valid && edges < 100) begin
            @(negedge clk);
            if (int'(subkey_addr) != (eff_dec ? nr_cur - k : k)) addr_err++;
            sv = (gap == 0) || (int'($urandom_range(99)) >= gap);
            subkey_valid = sv;
            subkey = rk[subkey_addr];
            @(posedge clk);
            #1;
            edges++;
            if (sv) k++;
            else stalls++;
        end
        subkey_valid = 1'b0;
        dout = data_out;
    endtask

    // drains DONE while offering a new request that must not be taken on the DONE->IDLE edge
    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        key_len   = 2'b01;
        check($sformatf("%s in_ready in DONE", tag), 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check($sformatf("%s out_valid after release", tag), 128'(out_valid), 128'(0));
        check($sformatf("%s in_ready after release", tag), 128'(in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] dout;
        int edges, stalls, aerr;

        vecs[0] = '{2'b11 & 2'b01, 1'b0, PT, 0, CT128};
        vecs[1] = '{2'b10, 1'b0, PT, 0, CT192};
        vecs[2] = '{2'b11, 1'b0, PT, 0, CT256};
        vecs[3] = '{2'b11, 1'b1, DEC_ON ? CT256 : PT, 0, DEC_ON ? PT : CT256};
        vecs[4] = '{2'b01, 1'b0, PT, 35, CT128};
        vecs[5] = '{2'b11, 1'b1, DEC_ON ? CT256 : PT, 35, DEC_ON ? PT : CT256};
        vecs[6] = '{2'b10, 1'b0, PT, 50, CT192};
        vecs[7] = '{2'b01, 1'b1, DEC_ON ? CT128 : PT, 40, DEC_ON ? PT : CT128};

        reset_n = 1'b1;
        in_valid = 1'b0;
        mode = 1'b0;
        key_len = 2'b00;
        data_in = '0;
        out_ready = 1'b0;
        subkey = '0;
        subkey_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset in_ready", 128'(in_ready), 128'(1));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset data_out", data_out, 128'(0));
        check("reset subkey_addr", 128'(subkey_addr), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run(vecs[i].kl, vecs[i].md, vecs[i].din, vecs[i].gap, dout, edges, stalls, aerr);
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d data_out", i), dout, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 128'(edges), 128'(nr_cur + 1 + stalls));
            check($sformatf("vec%0d subkey_addr errors", i), 128'(aerr), 128'(0));
            release_out($sformatf("vec%0d", i));
        end

        // backpressure: result held for 5 cycles with out_ready low
        run(2'b11, 1'b0, PT, 0, dout, edges, stalls, aerr);
        check("hold latency", 128'(edges), 128'(15));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("hold%0d data_out", i), data_out, CT256);
            check($sformatf("hold%0d in_ready", i), 128'(in_ready), 128'(0));
        end
        release_out("hold");

        // key_len=00 is never accepted
        @(negedge clk);
        in_valid = 1'b1;
        key_len  = 2'b00;
        data_in  = PT;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("kl00 in_ready %0d", i), 128'(in_ready), 128'(1));
            check($sformatf("kl00 subkey_addr %0d", i), 128'(subkey_addr), 128'(0));
        end
        in_valid = 1'b0;

        // reset in the middle of ROUND, then a clean block
        expand(2'b01);
        @(negedge clk);
        in_valid = 1'b1;
        key_len  = 2'b01;
        mode     = 1'b0;
        data_in  = PT;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            subkey_valid = 1'b1;
            subkey = rk[subkey_addr];
            @(posedge clk);
            #1;
        end
        check("midrst busy", 128'(in_ready), 128'(0));
        @(negedge clk);
        subkey_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst data_out", data_out, 128'(0));
        check("midrst in_ready", 128'(in_ready), 128'(1));
        check("midrst subkey_addr", 128'(subkey_addr), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run(2'b01, 1'b0, PT, 0, dout, edges, stalls, aerr);
        check("post-reset data_out", dout, CT128);
        check("post-reset latency", 128'(edges), 128'(11));
        release_out("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
